// File: rtl/framer_pkg.sv
// rtl/framer_pkg.sv - shared types for the audio framer
package framer_pkg;

    localparam int SAMPLE_W = 16;

    typedef enum logic [1:0] {
        FILL    = 2'd0,
        EMIT    = 2'd1,
        ADVANCE = 2'd2
    } framer_state_t;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

endpackage

// File: rtl/framer_ram.sv
// rtl/framer_ram.sv - simple dual-port sample buffer, 1-cycle synchronous read, no reset
module framer_ram #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem_q[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/audio_framer.sv
// rtl/audio_framer.sv - overlapping-frame builder: fills a circular buffer, streams
// FRAME_LEN samples oldest-first, then slides the window forward by HOP.
module audio_framer
    import framer_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int FRAME_LEN = 256,
    parameter int HOP       = 128
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last,
    output logic [15:0]       frame_cnt
);

    localparam int            AW        = $clog2(FRAME_LEN);
    localparam logic [AW-1:0] HOP_PTR   = AW'(HOP % FRAME_LEN);
    localparam logic [AW:0]   HOP_FILL  = (AW+1)'(HOP);
    localparam logic [AW:0]   FULL      = (AW+1)'(FRAME_LEN);
    localparam logic [AW-1:0] LAST_BEAT = AW'(FRAME_LEN - 1);

    framer_state_t     state_q, state_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     base_q, base_d;
    logic [AW:0]       fill_q, fill_d;
    logic [AW:0]       iss_cnt_q, iss_cnt_d;
    logic [AW-1:0]     beat_cnt_q, beat_cnt_d;
    logic [15:0]       frame_cnt_q, frame_cnt_d;
    logic              s_ready_q, s_ready_d;
    logic              inflight_q, inflight_d;
    logic [1:0]        occ_q, occ_d;
    logic [DATA_W-1:0] skid0_q, skid0_d;
    logic [DATA_W-1:0] skid1_q, skid1_d;

    logic              wr_en;
    logic              rd_en;
    logic [AW-1:0]     rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              push;
    logic              pop;
    logic [2:0]        pend;

    framer_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (FRAME_LEN),
        .ADDR_W (AW)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr_q),
        .wr_data (s_data),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    assign m_valid   = (occ_q != 2'd0);
    assign m_last    = m_valid && (beat_cnt_q == LAST_BEAT);
    assign m_data    = skid0_q;
    assign s_ready   = s_ready_q;
    assign frame_cnt = frame_cnt_q;

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        base_d      = base_q;
        fill_d      = fill_q;
        iss_cnt_d   = iss_cnt_q;
        beat_cnt_d  = beat_cnt_q;
        frame_cnt_d = frame_cnt_q;
        skid0_d     = skid0_q;
        skid1_d     = skid1_q;

        wr_en = s_valid && s_ready_q;
        push  = inflight_q;
        pop   = m_valid && m_ready;
        pend  = {1'b0, occ_q} + {2'b00, inflight_q};
        // Only issue a read if the skid buffer is guaranteed a free slot when it lands.
        rd_en   = (state_q == EMIT) && (iss_cnt_q != FULL) &&
                  ((pend <= 3'd1) || ((pend == 3'd2) && pop));
        rd_addr = base_q + iss_cnt_q[AW-1:0];

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            fill_d   = fill_q + 1'b1;
        end
        if (rd_en) begin
            iss_cnt_d = iss_cnt_q + 1'b1;
        end
        inflight_d = rd_en;

        occ_d = occ_q + {1'b0, push} - {1'b0, pop};
        if (pop) begin
            beat_cnt_d = beat_cnt_q + 1'b1;
            if (occ_q == 2'd2) begin
                skid0_d = skid1_q;
            end else if (push) begin
                skid0_d = rd_data;
            end
        end else if (push && (occ_q == 2'd0)) begin
            skid0_d = rd_data;
        end
        if (push && ((pop && (occ_q == 2'd2)) || (!pop && (occ_q == 2'd1)))) begin
            skid1_d = rd_data;
        end

        case (state_q)
            FILL: begin
                if (fill_q == FULL) begin
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (pop && m_last) begin
                    state_d = ADVANCE;
                end
            end
            ADVANCE: begin
                base_d      = base_q + HOP_PTR;
                fill_d      = fill_q - HOP_FILL;
                frame_cnt_d = frame_cnt_q + 16'd1;
                iss_cnt_d   = '0;
                state_d     = FILL;
            end
            default: state_d = FILL;
        endcase

        // Registered so that nothing is accepted during ADVANCE or the cycle after reset.
        s_ready_d = (state_d == FILL) && (fill_d != FULL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FILL;
            wr_ptr_q    <= '0;
            base_q      <= '0;
            fill_q      <= '0;
            iss_cnt_q   <= '0;
            beat_cnt_q  <= '0;
            frame_cnt_q <= '0;
            s_ready_q   <= 1'b0;
            inflight_q  <= 1'b0;
            occ_q       <= '0;
            skid0_q     <= '0;
            skid1_q     <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            base_q      <= base_d;
            fill_q      <= fill_d;
            iss_cnt_q   <= iss_cnt_d;
            beat_cnt_q  <= beat_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            s_ready_q   <= s_ready_d;
            inflight_q  <= inflight_d;
            occ_q       <= occ_d;
            skid0_q     <= skid0_d;
            skid1_q     <= skid1_d;
        end
    end

endmodule
